// File: rtl/fpdiv_pkg.sv
// Shared definitions for the fpdiv scheduler: sequencer states and BF16 constants.
package fpdiv_pkg;

    localparam int BF16_W = 16;

    localparam logic [BF16_W-1:0] QNAN = 16'h7FC0;
    localparam logic [BF16_W-1:0] PINF = 16'h7F80;
    localparam logic [BF16_W-1:0] ZERO = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        RECOVER
    } state_t;

endpackage

// File: rtl/fpdiv_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer (wrapping)
// and moves the pointer just past the winner when the grant is accepted.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr;

    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % N_REQ;
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[wrap_idx(int'(ptr), i)]) begin
                grant[wrap_idx(int'(ptr), i)] = 1'b1;
                grant_idx = IDX_W'(wrap_idx(int'(ptr), i));
                any       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && any) begin
            ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/fpdiv_sched.sv
// Shares one BF16 fpdiv among N_REQ clients: round-robin grant, operand hold,
// result capture with a watchdog that answers qNaN + error if the divider hangs.
module fpdiv_sched
    import fpdiv_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_x1,
    input  logic [16*N_REQ-1:0]   req_x2,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [15:0]           rsp_y,
    output logic                  rsp_err,
    output logic [15:0]           div_x1,
    output logic [15:0]           div_x2,
    output logic                  div_en,
    input  logic [15:0]           div_y,
    input  logic                  div_ready
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    logic [N_REQ-1:0] sel_oh;
    logic [CNT_W-1:0] wdog;

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             any;
    logic             accept;

    assign accept = (state == IDLE);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // All outputs are registered: the accept pulse and div_en rise on the edge
    // that leaves IDLE, so operands are already latched when the divider sees en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_y     <= ZERO;
            rsp_err   <= 1'b0;
            div_x1    <= ZERO;
            div_x2    <= ZERO;
            div_en    <= 1'b0;
            wdog      <= '0;
            sel_oh    <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        req_ready <= grant;
                        sel_oh    <= grant;
                        div_x1    <= req_x1[int'(grant_idx)*BF16_W +: BF16_W];
                        div_x2    <= req_x2[int'(grant_idx)*BF16_W +: BF16_W];
                        div_en    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wdog <= wdog + CNT_W'(1);
                    // A result arriving on the timeout cycle still wins.
                    if (div_ready) begin
                        rsp_y     <= div_y;
                        rsp_err   <= 1'b0;
                        rsp_valid <= sel_oh;
                        div_en    <= 1'b0;
                        state     <= RESP;
                    end else if (wdog == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_y     <= QNAN;
                        rsp_err   <= 1'b1;
                        rsp_valid <= sel_oh;
                        div_en    <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (|(rsp_ready & sel_oh)) begin
                        rsp_valid <= '0;
                        state     <= RECOVER;
                    end
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
